// File: rtl/piso_sender.sv
// Parallel-in / serial-out frame sender: accepts one WIDTH-bit word per handshake,
// shifts it out on d one bit per cycle (stallable by hold), then emits a one-cycle gap with done.
module piso_sender #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  input  logic             hold,
  output logic             d,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shifted;

  // The bit currently on d always sits at the head of shreg.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    shifted = shreg;
    if (MSB_FIRST) shifted = {shreg[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, shreg[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is a plain register, not a memory, so it is reset along with the rest.
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      d          <= IDLE_LEVEL;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load_valid) begin
            shreg      <= data_in;
            cnt        <= '0;
            d          <= head_bit(data_in);
            busy       <= 1'b1;
            load_ready <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (!hold) begin
            if (cnt == LAST) begin
              d     <= IDLE_LEVEL;
              done  <= 1'b1;
              state <= GAP;
            end else begin
              cnt   <= cnt + 1'b1;
              shreg <= shifted;
              d     <= head_bit(shifted);
            end
          end
        end
        GAP: begin
          done       <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          d          <= IDLE_LEVEL;
          done       <= 1'b0;
          busy       <= 1'b0;
          load_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/piso_sender.md
PISO_SENDER -- requirements
Module: piso_sender

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame (legal range 2..16).
REQ-002 Parameter MSB_FIRST, default 1, 1 = shift bit WIDTH-1 first, 0 = shift bit 0 first.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, level driven on D whenever no data bit is being sent.
REQ-004 Clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 Rst_n  input  1  asynchronous, active-low reset.
REQ-006 Load_valid  input  1  upstream asserts when Data_in holds a word to send.
REQ-007 Data_in  input  WIDTH  parallel word, sampled only on an accepted handshake.
REQ-008 Load_ready  output  1  high when the block can accept a word.
REQ-009 Hold  input  1  stall request; freezes shifting while high.
REQ-010 D  output  1  registered serial bit stream feeding the downstream D input of the shift block.
REQ-011 Busy  output  1  high while a frame is in progress (SHIFT or GAP).
REQ-012 Done  output  1  single-cycle pulse marking frame completion.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and GAP; encoding is free.
REQ-014 IDLE: Load_ready=1, Busy=0, D=IDLE_LEVEL, Done=0.
REQ-015 Handshake: a word is accepted at the rising edge where Load_valid=1 and Load_ready=1; Data_in is captured into an internal WIDTH-bit shift register, bit counter cleared to 0, next state SHIFT.
REQ-016 Accepted at edge N: D SHALL present data bit index i (order per MSB_FIRST) during the cycle following edge N+i, for i=0..WIDTH-1, absent Hold.
REQ-017 SHIFT: Load_ready=0, Busy=1; the counter advances by 1 per cycle and is sized ceil(log2(WIDTH)) bits, with no wrap-around inside a frame.
REQ-018 Hold=1 in SHIFT: D, the shift register and the counter SHALL keep their values; shifting resumes on the first edge with Hold=0; each bit is stretched by the number of held cycles.
REQ-019 Hold SHALL be ignored in IDLE and GAP; it does not block acceptance.
REQ-020 After the last bit (counter=WIDTH-1, Hold=0), the next edge SHALL enter GAP: D=IDLE_LEVEL, Busy=1, Load_ready=0, Done=1 for exactly that one cycle.
REQ-021 The GAP edge SHALL always return to IDLE; the earliest next acceptance is one cycle later, so consecutive frames are separated by exactly 2 IDLE_LEVEL cycles.
REQ-022 Load_valid asserted while Load_ready=0 SHALL have no effect; Data_in changes during a frame SHALL not alter the frame.
REQ-023 D, Busy, Load_ready and Done SHALL be driven directly from flops or from state decode only, with no combinational path from inputs.

Reset
REQ-024 Rst_n=0 SHALL, without waiting for Clk, force state IDLE, D=IDLE_LEVEL, Busy=0, Done=0, Load_ready=1, and clear the counter and shift register to 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; no Done is produced, and the first handshake after release starts a fresh frame.
REQ-026 Release of Rst_n is synchronous-safe: the first acceptance can occur on the first rising edge after Rst_n=1.

Verification (WIDTH=8, IDLE_LEVEL=0 unless stated)
REQ-027 MSB_FIRST=1, send 8'hA5 -> D=1,0,1,0,0,1,0,1 on the 8 cycles after acceptance; Done=1 on cycle 9; Load_ready=1 on cycle 10.
REQ-028 MSB_FIRST=0, send 8'h01 -> D=1,0,0,0,0,0,0,0, then GAP with D=0 and Done pulse.
REQ-029 Load_valid held high with 8'h3C then 8'hC3 -> two frames, exactly 2 zero cycles between them, 2 Done pulses in total.
REQ-030 Send 8'hF0, Hold=1 for 3 cycles while bit index 2 is on D -> bit 2 (=1) lasts 4 cycles; Done occurs 3 cycles later than in the unheld case.
REQ-031 Rst_n pulsed low during bit index 4 of 8'hFF -> D=0 and Busy=0 immediately; no Done; the next frame 8'h81 is sent correctly.
REQ-032 Load_valid pulsed with 8'h00 during a frame of 8'hAA -> ignored; only 8'hAA appears on D.
